pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch controller that sequences the 16-bit PC register. The PC register loads `npc` on every `clk` edge and has no enable or reset of its own. This block drives `npc` every cycle (hold, increment, redirect or reset vector), runs the instruction-memory request/ack handshake, and presents fetched instructions to decode with a valid/ready handshake. It sits between the PC register, instruction memory and the decode/execute stages.

Parameters:
- WIDTH, 16, width of PC, addresses and instruction words.
- RESET_VECTOR, 16'h0000, value forced onto `npc` during reset.
- INCR, 1, PC increment per fetched instruction (word-addressed memory).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pc  in  WIDTH  current value from the PC register.
- npc  out  WIDTH  next PC; the PC register loads it every edge.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  WIDTH  fetch address; equals `pc` whenever `imem_req`=1.
- imem_ack  in  1  memory returns `imem_rdata` this cycle.
- imem_rdata  in  WIDTH  fetched instruction word.
- instr_valid  out  1  `instr`/`instr_pc` valid to decode.
- instr  out  WIDTH  held instruction.
- instr_pc  out  WIDTH  address the held instruction came from.
- instr_ready  in  1  decode accepts the instruction this cycle.
- br_valid  in  1  redirect request from execute (one-cycle pulse).
- br_target  in  WIDTH  redirect address.
- halt_req  in  1  stop fetching after the current issue.
- resume  in  1  leave HALT (pulse).
- halted  out  1  high in HALT.
- issue_count  out  WIDTH  count of instructions accepted by decode.

Behaviour:
- Reset (`rst_n`=0 at an edge):
  - State goes to FETCH. `flush_q`, `target_q`, `instr_q`, `instr_pc_q` and `issue_count` are cleared to 0.
  - `npc`=RESET_VECTOR combinationally while `rst_n`=0, so `pc`=RESET_VECTOR in the first cycle after reset.
  - While `rst_n`=0: `imem_req`=0, `instr_valid`=0, `halted`=0.
  - Reset mid-transaction abandons any request. A late `imem_ack` in the first FETCH cycle is accepted as the response for RESET_VECTOR.
- `npc` defaults to `pc` (hold) in every state unless a rule below says otherwise.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`; both are held stable until `imem_ack`.
  - `br_valid` without `imem_ack`: set `flush_q`=1 and `target_q`=`br_target`. A later branch overwrites the saved target.
  - `imem_ack` with `br_valid`: discard the data, `npc`=`br_target`, clear `flush_q`, stay in FETCH.
  - `imem_ack` with `flush_q`=1 and no `br_valid`: discard the data, `npc`=`target_q`, clear `flush_q`, stay in FETCH.
  - `imem_ack` otherwise: `instr_q`<=`imem_rdata`, `instr_pc_q`<=`pc`, `npc`=`pc`+INCR (modulo 2^WIDTH, so FFFF->0000), go to ISSUE.
  - Minimum fetch latency is 1 cycle (ack in the first cycle of the request). There is no timeout.
- ISSUE:
  - `imem_req`=0. `instr_valid`=!`br_valid`.
  - `br_valid`: `npc`=`br_target`, drop `instr_q` without counting it, go to FETCH. This applies even if `instr_ready`=1 in the same cycle; the branch wins.
  - `instr_ready` without `br_valid`: `issue_count`+=1 (wraps), then go to HALT if `halt_req`=1, else to FETCH.
  - Not ready: hold `instr`/`instr_pc` stable and stay in ISSUE.
- HALT:
  - `halted`=1, `imem_req`=0, `instr_valid`=0.
  - `br_valid`: `npc`=`br_target`, stay in HALT.
  - `resume`: go to FETCH. If `resume` and `br_valid` arrive in the same cycle, both take effect.
  - `halt_req` is ignored outside the ISSUE handshake cycle.
- `instr`/`instr_pc` are registered; every other output is combinational from state and inputs.
- Steady state with an ack every FETCH cycle and ready every ISSUE cycle: one instruction per 2 cycles.

Test Plan:
1. Reset, then `imem_ack`=1 every FETCH cycle and `instr_ready`=1 → `imem_addr` sequence 0000, 0001, 0002, with `instr_pc` matching and `issue_count`=3 after 6 cycles.
2. Hold `instr_ready`=0 for 4 cycles in ISSUE with `instr`=16'hA5A5 → `instr_valid`=1 throughout, `instr` stable, `pc` stable at 0001, and no `imem_req`.
3. Delay ack 3 cycles and pulse `br_valid` with target 0x0040 in the 2nd wait cycle → `imem_addr` stays 0000 until ack, data is discarded, next `imem_addr`=0040, `issue_count` unchanged.
4. `br_valid` with target 0x0100 and `instr_ready` in the same ISSUE cycle → `instr_valid`=0 that cycle, count not incremented, next fetch at 0100.
5. `pc`=FFFF fetched and accepted → `npc`=0000 and the next fetch is at 0000.
6. `halt_req` at the handshake → `halted`=1 and no requests for 5 cycles; a `resume` pulse → FETCH at the held `pc`. Asserting `rst_n`=0 mid-FETCH at `pc`=0x0033 → `pc`=0000 next cycle, `issue_count`=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch sequencer: drives the next-PC every cycle, runs the instruction-memory
// request/ack handshake and hands fetched words to decode via valid/ready.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      INCR         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] npc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic [WIDTH-1:0] issue_count
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_flush;
  logic             w_flush_next;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] w_target_next;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_instr_pc;
  logic [WIDTH-1:0] r_count;
  logic             w_load;
  logic             w_issue;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_flush    <= 1'b0;
      r_target   <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_count    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_flush  <= w_flush_next;
      r_target <= w_target_next;
      if (w_load) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= pc;
      end
      if (w_issue) begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

  // A branch seen while a fetch is outstanding is remembered in r_flush/r_target
  // so the in-flight response is thrown away when it finally arrives.
  always_comb begin
    w_state_next  = r_state;
    w_flush_next  = r_flush;
    w_target_next = r_target;
    w_load        = 1'b0;
    w_issue       = 1'b0;
    npc           = pc;
    imem_req      = 1'b0;
    imem_addr     = pc;
    instr_valid   = 1'b0;
    halted        = 1'b0;

    if (!rst_n) begin
      npc = RESET_VECTOR;
    end else begin
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (br_valid) begin
              npc          = br_target;
              w_flush_next = 1'b0;
            end else if (r_flush) begin
              npc          = r_target;
              w_flush_next = 1'b0;
            end else begin
              w_load       = 1'b1;
              npc          = pc + WIDTH'(INCR);
              w_state_next = S_ISSUE;
            end
          end else if (br_valid) begin
            w_flush_next  = 1'b1;
            w_target_next = br_target;
          end
        end

        S_ISSUE: begin
          instr_valid = !br_valid;
          if (br_valid) begin
            npc          = br_target;
            w_state_next = S_FETCH;
          end else if (instr_ready) begin
            w_issue      = 1'b1;
            w_state_next = halt_req ? S_HALT : S_FETCH;
          end
        end

        S_HALT: begin
          halted = 1'b1;
          if (br_valid) begin
            npc = br_target;
          end
          if (resume) begin
            w_state_next = S_FETCH;
          end
        end

        default: begin
          w_state_next = S_FETCH;
        end
      endcase
    end
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign issue_count = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the PC register, replays a vector table and
// hand sequences, then runs random traffic against a behavioural fetch model.
module tb_pc_sequencer;

  typedef struct packed {
    logic        rstN;
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        br;
    logic [15:0] target;
    logic        halt;
    logic        resume;
  } stim_t;

  typedef struct packed {
    stim_t       in;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expValid;
    logic [15:0] expInstrPc;
    logic [15:0] expCount;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc = 16'h1234;
  logic [15:0] npc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        br_valid = 1'b0;
  logic [15:0] br_target = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        halted;
  logic [15:0] issue_count;

  int testsRun = 0;
  int testsFailed = 0;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .npc        (npc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .halt_req   (halt_req),
    .resume     (resume),
    .halted     (halted),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // The PC register itself: loads npc on every edge, no enable, no reset.
  always @(posedge clk) pc <= npc;

  // Behavioural model: "holding" an instruction for decode, "halted", and a
  // queue of at most one pending redirect target learned during a fetch.
  logic        mKnown = 1'b0, nKnown;
  logic        mHolding = 1'b0, nHolding;
  logic        mHalted = 1'b0, nHalted;
  logic [15:0] mRedirect[$];
  logic [15:0] nRedirect[$];
  logic [15:0] mPc, nPc, mCount, nCount, mInstr, nInstr, mInstrPc, nInstrPc;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic rstN, input logic ack, input logic [15:0] rdata,
                               input logic ready, input logic br, input logic [15:0] target,
                               input logic halt, input logic res);
    stim_t s;
    s.rstN = rstN; s.ack = ack; s.rdata = rdata; s.ready = ready;
    s.br = br; s.target = target; s.halt = halt; s.resume = res;
    return s;
  endfunction

  function automatic vec_t mkVec(input logic ack, input logic [15:0] rdata, input logic ready,
                                 input logic expReq, input logic [15:0] expAddr,
                                 input logic expValid, input logic [15:0] expInstrPc,
                                 input logic [15:0] expCount);
    vec_t v;
    v.in = mk(1'b1, ack, rdata, ready, 1'b0, 16'h0000, 1'b0, 1'b0);
    v.expReq = expReq; v.expAddr = expAddr; v.expValid = expValid;
    v.expInstrPc = expInstrPc; v.expCount = expCount;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge and check every output
  // against the model; the model's next state is staged for advance().
  task automatic applyStimulus(input stim_t s);
    logic        eReq, eValid, eHalted;
    logic [15:0] eNpc;
    @(negedge clk);
    rst_n = s.rstN; imem_ack = s.ack; imem_rdata = s.rdata; instr_ready = s.ready;
    br_valid = s.br; br_target = s.target; halt_req = s.halt; resume = s.resume;
    #1;
    eReq = 1'b0; eValid = 1'b0; eHalted = 1'b0; eNpc = mPc;
    nKnown = mKnown; nHolding = mHolding; nHalted = mHalted; nRedirect = mRedirect;
    nCount = mCount; nInstr = mInstr; nInstrPc = mInstrPc;
    if (!s.rstN) begin
      eNpc = 16'h0000;
      nKnown = 1'b1; nHolding = 1'b0; nHalted = 1'b0; nRedirect.delete();
      nCount = '0; nInstr = '0; nInstrPc = '0;
    end else if (mHalted) begin
      eHalted = 1'b1;
      if (s.br) eNpc = s.target;
      if (s.resume) nHalted = 1'b0;
    end else if (mHolding) begin
      eValid = !s.br;
      if (s.br) begin
        eNpc = s.target;
        nHolding = 1'b0;
      end else if (s.ready) begin
        nCount = mCount + 16'd1;
        nHolding = 1'b0;
        nHalted = s.halt;
      end
    end else begin
      eReq = 1'b1;
      if (s.ack) begin
        if (s.br) begin
          eNpc = s.target;
          nRedirect.delete();
        end else if (mRedirect.size() > 0) begin
          eNpc = mRedirect[0];
          nRedirect.delete();
        end else begin
          nInstr = s.rdata;
          nInstrPc = mPc;
          eNpc = mPc + 16'd1;
          nHolding = 1'b1;
        end
      end else if (s.br) begin
        nRedirect.delete();
        nRedirect.push_back(s.target);
      end
    end
    nPc = eNpc;
    checkOutput("npc", npc, eNpc);
    checkOutput("imem_req", {15'd0, imem_req}, {15'd0, eReq});
    checkOutput("instr_valid", {15'd0, instr_valid}, {15'd0, eValid});
    checkOutput("halted", {15'd0, halted}, {15'd0, eHalted});
    if (mKnown) begin
      checkOutput("pc", pc, mPc);
      checkOutput("issue_count", issue_count, mCount);
      checkOutput("instr", instr, mInstr);
      checkOutput("instr_pc", instr_pc, mInstrPc);
      if (eReq) checkOutput("imem_addr", imem_addr, mPc);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    mKnown = nKnown; mHolding = nHolding; mHalted = nHalted; mRedirect = nRedirect;
    mPc = nPc; mCount = nCount; mInstr = nInstr; mInstrPc = nInstrPc;
  endtask

  task automatic cycle(input stim_t s);
    applyStimulus(s);
    advance();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = mkVec(1'b1, 16'h1000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'd0);
    vecs[1] = mkVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'd0);
    vecs[2] = mkVec(1'b1, 16'h1001, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'd1);
    vecs[3] = mkVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'd1);
    vecs[4] = mkVec(1'b1, 16'h1002, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0001, 16'd2);
    vecs[5] = mkVec(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'd2);
    vecs[6] = mkVec(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0002, 16'd3);

    // Reset with a stray ack present; outputs must stay quiet.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
      checkOutput("rst_npc", npc, 16'h0000);
      advance();
    end

    // Streaming fetch/issue table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].in);
      checkOutput("tbl_req", {15'd0, imem_req}, {15'd0, vecs[i].expReq});
      if (vecs[i].expReq) checkOutput("tbl_addr", imem_addr, vecs[i].expAddr);
      checkOutput("tbl_valid", {15'd0, instr_valid}, {15'd0, vecs[i].expValid});
      checkOutput("tbl_instr_pc", instr_pc, vecs[i].expInstrPc);
      checkOutput("tbl_count", issue_count, vecs[i].expCount);
      advance();
    end

    // Decode stalls: instruction held stable, no new request.
    cycle(mk(1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
      checkOutput("stall_valid", {15'd0, instr_valid}, 16'd1);
      checkOutput("stall_instr", instr, 16'hA5A5);
      checkOutput("stall_pc", pc, 16'h0004);
      checkOutput("stall_req", {15'd0, imem_req}, 16'd0);
      advance();
    end
    cycle(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));

    // Slow ack with a branch in the second wait cycle: response discarded.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(1'b1, i == 3, 16'hDEAD, 1'b0, i == 1, 16'h0040, 1'b0, 1'b0));
      checkOutput("slow_addr", imem_addr, 16'h0004);
      advance();
    end
    applyStimulus(mk(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    checkOutput("redir_addr", imem_addr, 16'h0040);
    checkOutput("redir_count", issue_count, 16'd4);
    advance();

    // Branch and ready in the same issue cycle: branch wins.
    applyStimulus(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0));
    checkOutput("brwin_valid", {15'd0, instr_valid}, 16'd0);
    advance();
    applyStimulus(mk(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0));
    checkOutput("brwin_addr", imem_addr, 16'h0100);
    checkOutput("brwin_count", issue_count, 16'd4);
    advance();

    // Fetch at FFFF wraps to 0000.
    applyStimulus(mk(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    checkOutput("wrap_npc", npc, 16'h0000);
    advance();
    applyStimulus(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
    checkOutput("wrap_instr_pc", instr_pc, 16'hFFFF);
    advance();
    applyStimulus(mk(1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    checkOutput("wrap_addr", imem_addr, 16'h0000);
    checkOutput("wrap_count", issue_count, 16'd5);
    advance();

    // Halt at the handshake, idle, then resume at the held PC.
    cycle(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mk(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0));
      checkOutput("halt_flag", {15'd0, halted}, 16'd1);
      checkOutput("halt_req_off", {15'd0, imem_req}, 16'd0);
      advance();
    end
    cycle(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1));
    applyStimulus(mk(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0033, 1'b0, 1'b0));
    checkOutput("resume_addr", imem_addr, 16'h0001);
    checkOutput("resume_halted", {15'd0, halted}, 16'd0);
    advance();

    // Reset in the middle of a fetch at 0033.
    applyStimulus(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    checkOutput("mid_addr", imem_addr, 16'h0033);
    advance();
    applyStimulus(mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    checkOutput("mid_rst_req", {15'd0, imem_req}, 16'd0);
    advance();
    applyStimulus(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    checkOutput("post_rst_pc", pc, 16'h0000);
    checkOutput("post_rst_count", issue_count, 16'd0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      stim_t s;
      s.rstN   = ($urandom_range(0, 49) != 0);
      s.ack    = ($urandom_range(0, 1) != 0);
      s.rdata  = 16'($urandom);
      s.ready  = ($urandom_range(0, 1) != 0);
      s.br     = ($urandom_range(0, 9) == 0);
      s.target = 16'($urandom);
      s.halt   = ($urandom_range(0, 4) == 0);
      s.resume = ($urandom_range(0, 4) == 0);
      cycle(s);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
